// File: rtl/multi_channel_correlator.sv
`default_nettype none
// ============================================================================
// Module      : multi_channel_correlator
// Description : NUM_CH independent sign-bit correlator channels. Each channel
//               has a carrier NCO (I/Q LO), a code NCO that clocks a 10-bit
//               LFSR code generator, and signed I/Q accumulators. These are
//               dumped once per code epoch into a per-channel dump register.
//               Pending dumps are drained through one valid/ready port with
//               lowest-index-first priority.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   wb_clk_i        clock
//   wb_rst_i        synchronous active-high reset
//   sample_i        IF sample sign bit (1 = negative)
//   sample_valid_i  sample_i valid this cycle
//   cfg_we_i        configuration write strobe
//   cfg_ch_i        target channel (indices >= NUM_CH are ignored)
//   cfg_addr_i      0 carrier freq, 1 code freq, 2 control, 3 reserved
//   cfg_data_i      write data; control = {seed[10:1], enable[0]}
//   lo_o            per-channel in-phase LO bit
//   prompt_o        per-channel prompt chip (0 while the channel is disabled)
//   dump_valid_o    dump word available
//   dump_ready_i    consumer accepts the dump word
//   dump_ch_o       channel index of the dump word
//   dump_i_o        signed I sum
//   dump_q_o        signed Q sum
//   overrun_o       sticky per-channel overrun flag
// ----------------------------------------------------------------------------
// Build option
//   CORR_SATURATE_EN  defined: accumulators clamp at the signed limits.
//                     undefined: accumulators wrap modulo 2^ACC_W.
// Note: NCO_W must be at least 11 so the control word can carry the seed.
// ============================================================================
module multi_channel_correlator #(
    parameter int NUM_CH      = 4,
    parameter int NCO_W       = 32,
    parameter int ACC_W       = 16,
    parameter int EPOCH_CHIPS = 1023
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              sample_i,
    input  logic              sample_valid_i,
    input  logic              cfg_we_i,
    input  logic [2:0]        cfg_ch_i,
    input  logic [1:0]        cfg_addr_i,
    input  logic [NCO_W-1:0]  cfg_data_i,
    output logic [NUM_CH-1:0] lo_o,
    output logic [NUM_CH-1:0] prompt_o,
    output logic              dump_valid_o,
    input  logic              dump_ready_i,
    output logic [2:0]        dump_ch_o,
    output logic [ACC_W-1:0]  dump_i_o,
    output logic [ACC_W-1:0]  dump_q_o,
    output logic [NUM_CH-1:0] overrun_o
);

    localparam logic [9:0]       c_lfsr_ones = 10'h3FF;
    localparam logic [9:0]       c_last_chip = 10'(EPOCH_CHIPS - 1);
    localparam logic [ACC_W-1:0] c_acc_one   = ACC_W'(1);
`ifdef CORR_SATURATE_EN
    localparam logic [ACC_W-1:0] c_acc_max   = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] c_acc_min   = {1'b1, {(ACC_W-1){1'b0}}};
`endif

    // One +/-1 accumulator step; neg selects -1.
    function automatic logic [ACC_W-1:0] acc_step(input logic [ACC_W-1:0] acc,
                                                  input logic             neg);
`ifdef CORR_SATURATE_EN
        if (neg) begin
            return (acc == c_acc_min) ? acc : acc - c_acc_one;
        end
        return (acc == c_acc_max) ? acc : acc + c_acc_one;
`else
        return neg ? acc - c_acc_one : acc + c_acc_one;
`endif
    endfunction

    // Output-port registers
    logic              r_dump_valid;
    logic [2:0]        r_dump_ch;
    logic [ACC_W-1:0]  r_dump_i;
    logic [ACC_W-1:0]  r_dump_q;

    // Next-state view of every channel's pending flag and dump register,
    // so the output port can follow them on the same clock edge.
    logic [NUM_CH-1:0] w_pend_nxt;
    logic [ACC_W-1:0]  w_ch_dump_i [NUM_CH];
    logic [ACC_W-1:0]  w_ch_dump_q [NUM_CH];

    // ------------------------------------------------------------------------
    // Per-channel datapath
    // ------------------------------------------------------------------------
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [NCO_W-1:0] r_carrier_freq;
        logic [NCO_W-1:0] r_code_freq;
        logic [NCO_W-1:0] r_carrier_phase;
        logic [NCO_W-1:0] r_code_phase;
        logic [9:0]       r_seed;
        logic [9:0]       r_lfsr;
        logic [9:0]       r_chip_cnt;
        logic             r_enable;
        logic             r_pending;
        logic             r_overrun;
        logic [ACC_W-1:0] r_acc_i;
        logic [ACC_W-1:0] r_acc_q;
        logic [ACC_W-1:0] r_dump_i_reg;
        logic [ACC_W-1:0] r_dump_q_reg;

        logic             w_cfg_hit;
        logic             w_adv;
        logic             w_lo_i;
        logic             w_lo_q;
        logic             w_prompt;
        logic             w_carry;
        logic             w_epoch_end;
        logic             w_ack;
        logic [NCO_W-1:0] w_code_sum;
        logic [9:0]       w_lfsr_shift;
        logic [9:0]       w_seed_lfsr;
        logic [9:0]       w_cfg_seed_lfsr;
        logic [ACC_W-1:0] w_acc_i_sum;
        logic [ACC_W-1:0] w_acc_q_sum;
        logic             w_pending_nxt;
        logic [ACC_W-1:0] w_dump_i_nxt;
        logic [ACC_W-1:0] w_dump_q_nxt;

        // Full 3-bit compare, so indices >= NUM_CH never alias a channel.
        assign w_cfg_hit = cfg_we_i && (cfg_ch_i == 3'(g));
        assign w_adv     = sample_valid_i & r_enable;

        // LO and prompt come from the state before this sample's update.
        assign w_lo_i   = r_carrier_phase[NCO_W-1];
        assign w_lo_q   = r_carrier_phase[NCO_W-1] ^ r_carrier_phase[NCO_W-2];
        assign w_prompt = r_lfsr[9];

        assign {w_carry, w_code_sum} = {1'b0, r_code_phase} + {1'b0, r_code_freq};

        // x^10 + x^3 + 1, shifting toward bit 9 (the output stage).
        assign w_lfsr_shift    = {r_lfsr[8:0], r_lfsr[9] ^ r_lfsr[2]};
        // An all-zero seed would lock the LFSR, so it means all-ones.
        assign w_seed_lfsr     = (r_seed == 10'd0) ? c_lfsr_ones : r_seed;
        assign w_cfg_seed_lfsr = (cfg_data_i[10:1] == 10'd0) ? c_lfsr_ones
                                                             : cfg_data_i[10:1];

        assign w_epoch_end = w_adv & w_carry & (r_chip_cnt == c_last_chip);
        assign w_ack       = r_dump_valid & dump_ready_i & (r_dump_ch == 3'(g));

        assign w_acc_i_sum = acc_step(r_acc_i, sample_i ^ w_lo_i ^ w_prompt);
        assign w_acc_q_sum = acc_step(r_acc_q, sample_i ^ w_lo_q ^ w_prompt);

        always_comb begin
            w_pending_nxt = r_pending;
            w_dump_i_nxt  = r_dump_i_reg;
            w_dump_q_nxt  = r_dump_q_reg;
            if (w_ack) begin
                w_pending_nxt = 1'b0;
            end
            if (w_epoch_end) begin
                w_pending_nxt = 1'b1;
                w_dump_i_nxt  = w_acc_i_sum;
                w_dump_q_nxt  = w_acc_q_sum;
            end
            // A restart discards any undelivered dump.
            if (w_cfg_hit && (cfg_addr_i == 2'd2) && cfg_data_i[0]) begin
                w_pending_nxt = 1'b0;
            end
        end

        always_ff @(posedge wb_clk_i) begin
            if (wb_rst_i) begin
                r_carrier_freq  <= '0;
                r_code_freq     <= '0;
                r_carrier_phase <= '0;
                r_code_phase    <= '0;
                r_seed          <= '0;
                r_lfsr          <= c_lfsr_ones;
                r_chip_cnt      <= '0;
                r_enable        <= 1'b0;
                r_pending       <= 1'b0;
                r_overrun       <= 1'b0;
                r_acc_i         <= '0;
                r_acc_q         <= '0;
                r_dump_i_reg    <= '0;
                r_dump_q_reg    <= '0;
            end else begin
                r_pending    <= w_pending_nxt;
                r_dump_i_reg <= w_dump_i_nxt;
                r_dump_q_reg <= w_dump_q_nxt;

                // Overwriting a dump that is being accepted this cycle is
                // not a loss of data.
                if (w_epoch_end && r_pending && !w_ack) begin
                    r_overrun <= 1'b1;
                end

                if (w_adv) begin
                    r_carrier_phase <= r_carrier_phase + r_carrier_freq;
                    r_code_phase    <= w_code_sum;
                    r_acc_i         <= w_epoch_end ? '0 : w_acc_i_sum;
                    r_acc_q         <= w_epoch_end ? '0 : w_acc_q_sum;
                    if (w_carry) begin
                        if (r_chip_cnt == c_last_chip) begin
                            r_chip_cnt <= '0;
                            r_lfsr     <= w_seed_lfsr;
                        end else begin
                            r_chip_cnt <= r_chip_cnt + 10'd1;
                            r_lfsr     <= w_lfsr_shift;
                        end
                    end
                end

                // Placed last: a write overrides the same-cycle sample update,
                // and that sample still used the previous register values.
                if (w_cfg_hit) begin
                    case (cfg_addr_i)
                        2'd0: r_carrier_freq <= cfg_data_i;
                        2'd1: r_code_freq    <= cfg_data_i;
                        2'd2: begin
                            r_seed   <= cfg_data_i[10:1];
                            r_enable <= cfg_data_i[0];
                            if (cfg_data_i[0]) begin
                                r_carrier_phase <= '0;
                                r_code_phase    <= '0;
                                r_chip_cnt      <= '0;
                                r_acc_i         <= '0;
                                r_acc_q         <= '0;
                                r_lfsr          <= w_cfg_seed_lfsr;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end

        assign lo_o[g]        = w_lo_i;
        assign prompt_o[g]    = r_enable & w_prompt;
        assign overrun_o[g]   = r_overrun;
        assign w_pend_nxt[g]  = w_pending_nxt;
        assign w_ch_dump_i[g] = w_dump_i_nxt;
        assign w_ch_dump_q[g] = w_dump_q_nxt;
    end

    // ------------------------------------------------------------------------
    // Dump arbitration
    // ------------------------------------------------------------------------
    logic             w_any;
    logic             w_stall_keep;
    logic [2:0]       w_sel;
    logic [ACC_W-1:0] w_sel_i;
    logic [ACC_W-1:0] w_sel_q;

    always_comb begin
        w_any        = |w_pend_nxt;
        w_stall_keep = 1'b0;
        w_sel        = '0;
        w_sel_i      = '0;
        w_sel_q      = '0;

        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (w_pend_nxt[i]) begin
                w_sel = 3'(i);
            end
        end

        // A stalled word keeps its channel even if a lower index becomes
        // pending; its data may still change if that channel is overwritten.
        for (int i = 0; i < NUM_CH; i++) begin
            if (r_dump_valid && !dump_ready_i && (r_dump_ch == 3'(i)) && w_pend_nxt[i]) begin
                w_stall_keep = 1'b1;
            end
        end
        if (w_stall_keep) begin
            w_sel = r_dump_ch;
        end

        for (int i = 0; i < NUM_CH; i++) begin
            if (w_any && (w_sel == 3'(i))) begin
                w_sel_i = w_ch_dump_i[i];
                w_sel_q = w_ch_dump_q[i];
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_dump_valid <= 1'b0;
            r_dump_ch    <= '0;
            r_dump_i     <= '0;
            r_dump_q     <= '0;
        end else begin
            r_dump_valid <= w_any;
            r_dump_ch    <= w_sel;
            r_dump_i     <= w_sel_i;
            r_dump_q     <= w_sel_q;
        end
    end

    assign dump_valid_o = r_dump_valid;
    assign dump_ch_o    = r_dump_ch;
    assign dump_i_o     = r_dump_i;
    assign dump_q_o     = r_dump_q;

endmodule
`default_nettype wire

// File: tb/tb_multi_channel_correlator.sv
`default_nettype none
// ============================================================================
// Module      : tb_multi_channel_correlator
// Description : Directed self-checking bench for multi_channel_correlator.
//               dut  : NUM_CH=2, ACC_W=16, EPOCH_CHIPS=4
//               dut2 : NUM_CH=1, ACC_W=6,  EPOCH_CHIPS=4 (accumulator limits)
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multi_channel_correlator;

    logic        clk;
    logic        rst;
    logic        sample;
    logic        sample_valid;
    logic        cfg_we;
    logic        cfg_we2;
    logic [2:0]  cfg_ch;
    logic [1:0]  cfg_addr;
    logic [31:0] cfg_data;

    logic [1:0]  lo;
    logic [1:0]  prompt;
    logic        dv;
    logic        dready;
    logic [2:0]  dch;
    logic [15:0] di;
    logic [15:0] dq;
    logic [1:0]  ovr;

    logic [0:0]  lo2;
    logic [0:0]  prompt2;
    logic        dv2;
    logic        dready2;
    logic [2:0]  dch2;
    logic [5:0]  di2;
    logic [5:0]  dq2;
    logic [0:0]  ovr2;

    int checks = 0;
    int errors = 0;

    multi_channel_correlator #(
        .NUM_CH      (2),
        .NCO_W       (32),
        .ACC_W       (16),
        .EPOCH_CHIPS (4)
    ) dut (
        .wb_clk_i       (clk),
        .wb_rst_i       (rst),
        .sample_i       (sample),
        .sample_valid_i (sample_valid),
        .cfg_we_i       (cfg_we),
        .cfg_ch_i       (cfg_ch),
        .cfg_addr_i     (cfg_addr),
        .cfg_data_i     (cfg_data),
        .lo_o           (lo),
        .prompt_o       (prompt),
        .dump_valid_o   (dv),
        .dump_ready_i   (dready),
        .dump_ch_o      (dch),
        .dump_i_o       (di),
        .dump_q_o       (dq),
        .overrun_o      (ovr)
    );

    multi_channel_correlator #(
        .NUM_CH      (1),
        .NCO_W       (32),
        .ACC_W       (6),
        .EPOCH_CHIPS (4)
    ) dut2 (
        .wb_clk_i       (clk),
        .wb_rst_i       (rst),
        .sample_i       (sample),
        .sample_valid_i (sample_valid),
        .cfg_we_i       (cfg_we2),
        .cfg_ch_i       (cfg_ch),
        .cfg_addr_i     (cfg_addr),
        .cfg_data_i     (cfg_data),
        .lo_o           (lo2),
        .prompt_o       (prompt2),
        .dump_valid_o   (dv2),
        .dump_ready_i   (dready2),
        .dump_ch_o      (dch2),
        .dump_i_o       (di2),
        .dump_q_o       (dq2),
        .overrun_o      (ovr2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cfg(input logic [2:0] ch, input logic [1:0] addr, input logic [31:0] data);
        cfg_we   = 1'b1;
        cfg_ch   = ch;
        cfg_addr = addr;
        cfg_data = data;
        step();
        cfg_we   = 1'b0;
    endtask

    task automatic cfg2(input logic [2:0] ch, input logic [1:0] addr, input logic [31:0] data);
        cfg_we2  = 1'b1;
        cfg_ch   = ch;
        cfg_addr = addr;
        cfg_data = data;
        step();
        cfg_we2  = 1'b0;
    endtask

    task automatic run(input int n, input logic s);
        sample       = s;
        sample_valid = 1'b1;
        repeat (n) step();
        sample_valid = 1'b0;
        sample       = 1'b0;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; sample = 1'b0; sample_valid = 1'b0;
        cfg_we = 1'b0; cfg_we2 = 1'b0; cfg_ch = '0; cfg_addr = '0; cfg_data = '0;
        dready = 1'b0; dready2 = 1'b0;
        step(); step();
        rst = 1'b0;
        step();

        // Reset state
        check("rst_valid",  dv, 0);
        check("rst_ch",     dch, 0);
        check("rst_i",      $signed(di), 0);
        check("rst_q",      $signed(dq), 0);
        check("rst_ovr",    ovr, 0);
        check("rst_lo",     lo, 0);
        check("rst_prompt", prompt, 0);

        // ch0: code 2^31 (chip every 2 samples), carrier 0, seed 3FF
        cfg(3'd0, 2'd1, 32'h8000_0000);
        cfg(3'd0, 2'd0, 32'h0);
        cfg(3'd0, 2'd2, 32'h7FF);
        check("en_prompt", prompt, 2'b01);
        run(8, 1'b0);
        check("e1_valid", dv, 1);
        check("e1_ch",    dch, 0);
        check("e1_i",     $signed(di), -8);
        check("e1_q",     $signed(dq), -8);
        check("e1_ovr",   ovr, 0);

        // Second epoch with the first still unread
        run(8, 1'b0);
        check("ov_flag",  ovr, 2'b01);
        check("ov_valid", dv, 1);
        check("ov_ch",    dch, 0);
        check("ov_i",     $signed(di), -8);
        dready = 1'b1;
        step();
        dready = 1'b0;
        check("ov_drain", dv, 0);
        check("ov_stick", ovr, 2'b01);

        // Non-trivial seed: prompt chips 1,1,1,0 -> -6 + 2
        pulse_reset();
        check("r2_ovr", ovr, 0);
        cfg(3'd0, 2'd1, 32'h8000_0000);
        cfg(3'd0, 2'd2, 32'h701);
        run(6, 1'b0);
        check("seed_prompt", prompt, 2'b00);
        run(2, 1'b0);
        check("seed_valid", dv, 1);
        check("seed_i",     $signed(di), -4);
        check("seed_q",     $signed(dq), -4);
        dready = 1'b1; step(); dready = 1'b0;

        // ch1 with carrier 2^30: LO_I 0,0,1,1  LO_Q 0,1,1,0
        pulse_reset();
        cfg(3'd1, 2'd0, 32'h4000_0000);
        cfg(3'd1, 2'd1, 32'h8000_0000);
        cfg(3'd1, 2'd2, 32'h7FF);
        check("lo_start", lo, 2'b00);
        run(2, 1'b1);
        check("lo_half", lo, 2'b10);
        run(2, 1'b0);
        run(2, 1'b1);
        run(2, 1'b0);
        check("iq_valid",  dv, 1);
        check("iq_ch",     dch, 1);
        check("iq_i",      $signed(di), 8);
        check("iq_q",      $signed(dq), 0);
        check("iq_prompt", prompt, 2'b10);
        dready = 1'b1; step(); dready = 1'b0;

        // Two identical channels; writes to index 2 and address 3 ignored
        pulse_reset();
        dready = 1'b1;
        cfg(3'd0, 2'd1, 32'h8000_0000);
        cfg(3'd1, 2'd1, 32'h8000_0000);
        cfg(3'd0, 2'd2, 32'h7FF);
        cfg(3'd1, 2'd2, 32'h001);
        cfg(3'd2, 2'd2, 32'h0);
        cfg(3'd0, 2'd3, 32'h0);
        run(8, 1'b0);
        check("arb0_valid", dv, 1);
        check("arb0_ch",    dch, 0);
        check("arb0_i",     $signed(di), -8);
        step();
        check("arb1_valid", dv, 1);
        check("arb1_ch",    dch, 1);
        check("arb1_i",     $signed(di), -8);
        check("arb1_q",     $signed(dq), -8);
        step();
        check("arb_empty",  dv, 0);
        dready = 1'b0;

        // Reset mid-epoch discards partial sums
        pulse_reset();
        cfg(3'd0, 2'd1, 32'h8000_0000);
        cfg(3'd0, 2'd2, 32'h7FF);
        run(5, 1'b0);
        pulse_reset();
        check("mid_valid", dv, 0);
        check("mid_i",     $signed(di), 0);
        cfg(3'd0, 2'd1, 32'h8000_0000);
        cfg(3'd0, 2'd2, 32'h7FF);
        run(8, 1'b0);
        check("mid_dump_valid", dv, 1);
        check("mid_dump_i",     $signed(di), -8);
        dready = 1'b1; step(); dready = 1'b0;
        check("mid_one_dump", dv, 0);

        // 6-bit accumulator over a 64-sample epoch of -1 steps
        pulse_reset();
        cfg2(3'd0, 2'd1, 32'h1000_0000);
        cfg2(3'd0, 2'd2, 32'h7FF);
        run(63, 1'b0);
        check("lim_early", dv2, 0);
        run(1, 1'b0);
        check("lim_valid", dv2, 1);
`ifdef CORR_SATURATE_EN
        check("lim_i", $signed(di2), -32);
        check("lim_q", $signed(dq2), -32);
`else
        check("lim_i", $signed(di2), 0);
        check("lim_q", $signed(dq2), 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
